// File: rtl/ntt_ctrl.sv
// ntt_ctrl: issue/drain sequencer for one RBFU lane over a 256-coefficient Kyber polynomial
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, mode           request pulse (sampled in IDLE) and operation select
//                         (00 NTT, 01 INTT, 10 PWM when NTT_CTRL_PWM_EN is defined, 11 reserved)
//   busy, done            running flag; one-cycle completion pulse
//   opcode                RBFU opcode, delayed MEM_LAT cycles to line up with RAM data
//   rd_en, rd_addr_a/b    coefficient read issue strobe and addresses
//   tw_idx                twiddle ROM index for the issued pair
//   wr_en, wr_addr_a/b    write-back strobe and addresses, delayed MEM_LAT+BFU_LAT cycles
//   layer                 current layer 0..6 (debug)
//
// Optional feature: define NTT_CTRL_PWM_EN to make mode 10 (pointwise multiply) legal.
module ntt_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int BFU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic [1:0] opcode,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_idx,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b,
    output logic [2:0] layer
);
    localparam int D = MEM_LAT + BFU_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef struct packed {
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
    } wb_t;

    state_t     state, state_nx;
    logic [6:0] cnt, cnt_nx;
    logic [2:0] layer_nx;
    logic [1:0] mode_r, mode_nx;
    logic       legal, pwm, last;
    logic [1:0] op_src;
    logic [1:0] op_q [MEM_LAT];
    wb_t        dl [D];
    logic [2:0] s;
    logic [6:0] g;
    logic [7:0] a_c, b_c;
    logic [6:0] tw_c;

`ifdef NTT_CTRL_PWM_EN
    assign legal = mode != 2'b11;
    assign pwm   = mode_r == 2'b10;
`else
    assign legal = !mode[1];
    assign pwm   = 1'b0;
`endif

    // PWM is a single pass; NTT/INTT run layers 0..6
    assign last   = pwm || layer == 3'd6;
    assign op_src = pwm ? {1'b1, cnt[0]} : mode_r;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        layer_nx = layer;
        mode_nx  = mode_r;
        case (state)
            IDLE: if (start && legal) begin
                state_nx = ISSUE;
                cnt_nx   = '0;
                layer_nx = '0;
                mode_nx  = mode;
            end
            // cnt wraps 127 -> 0, so the drain count starts from zero for free
            ISSUE: begin
                cnt_nx   = cnt + 7'd1;
                state_nx = cnt == 7'd127 ? DRAIN : ISSUE;
            end
            DRAIN: begin
                cnt_nx = cnt + 7'd1;
                if (cnt == 7'(D - 1)) begin
                    cnt_nx   = '0;
                    state_nx = last ? DONE : ISSUE;
                    layer_nx = last ? layer : layer + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                layer_nx = '0;
            end
        endcase
    end

    // Butterfly pair: split j at bit s (s = log2 len), insert a zero there for
    // the lower address and a one for the upper address.
    always_comb begin
        s    = mode_r[0] ? layer + 3'd1 : 3'd7 - layer;
        g    = cnt >> s;
        a_c  = (({1'b0, g} << s) << 1) | ({1'b0, cnt} & ((8'd1 << s) - 8'd1));
        b_c  = a_c | (8'd1 << s);
        tw_c = mode_r[0] ? 7'((8'd128 >> layer) - 8'd1 - {1'b0, g}) : (7'd1 << layer) + g;
`ifdef NTT_CTRL_PWM_EN
        if (pwm) begin
            a_c  = {1'b0, cnt[6:1], 1'b0};
            b_c  = {1'b0, cnt[6:1], 1'b1};
            tw_c = 7'd64 + {2'b00, cnt[6:2]};
        end
`endif
    end

    assign busy      = state == ISSUE || state == DRAIN;
    assign done      = state == DONE;
    assign rd_en     = state == ISSUE;
    assign rd_addr_a = rd_en ? a_c : '0;
    assign rd_addr_b = rd_en ? b_c : '0;
    assign tw_idx    = rd_en ? tw_c : '0;
    assign opcode    = op_q[MEM_LAT-1];
    assign wr_en     = dl[D-1].v;
    assign wr_addr_a = dl[D-1].a;
    assign wr_addr_b = dl[D-1].b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            layer  <= '0;
            mode_r <= '0;
            op_q   <= '{default: '0};
            dl     <= '{default: '0};
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            layer   <= layer_nx;
            mode_r  <= mode_nx;
            op_q[0] <= op_src;
            for (int i = 1; i < MEM_LAT; i++) op_q[i] <= op_q[i-1];
            dl[0] <= '{v: rd_en, a: rd_addr_a, b: rd_addr_b};
            for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
        end
    end
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: checks ntt_ctrl against a cycle-schedule reference model
module tb_ntt_ctrl;
    localparam int MEM_LAT = 1;
    localparam int BFU_LAT = 4;
    localparam int D = MEM_LAT + BFU_LAT;
    localparam int P = 128 + D;
`ifdef NTT_CTRL_PWM_EN
    localparam bit PWM = 1'b1;
`else
    localparam bit PWM = 1'b0;
`endif

    logic       clk, rst, start;
    logic [1:0] mode;
    logic       busy, done, rd_en, wr_en;
    logic [1:0] opcode;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_idx;
    logic [2:0] layer;

    ntt_ctrl #(.MEM_LAT(MEM_LAT), .BFU_LAT(BFU_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .opcode(opcode),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .layer(layer)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cur_c = 0;
    int done_cnt = 0, accepted = 0;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {int addr; int wc;} pend_t;
    pend_t pend[$];

    typedef struct {int md; int cyc; int a; int b; int tw;} vec_t;
    vec_t vt[6];

    int cap_a [2][1024];
    int cap_b [2][1024];
    int cap_tw[2][1024];
    int cap_wa[2][1024];
    bit cap_wr[2][1024];
    bit cap_dn[2][1024];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got %0d, expected %0d", n, cur_c, act, exp);
        end
    endtask

    function automatic bit is_issue(input int md, input int c, output int l, output int j);
        int nl;
        nl = md == 2 ? 1 : 7;
        l = 0;
        j = 0;
        if (c < 1) return 0;
        l = (c - 1) / P;
        j = (c - 1) % P;
        return l < nl && j < 128;
    endfunction

    function automatic void addr_of(input int md, input int l, input int j,
                                    output int a, output int b, output int tw);
        int len, g;
        if (md == 2) begin
            a  = 2 * (j / 2);
            b  = a + 1;
            tw = 64 + j / 4;
        end else begin
            len = md == 0 ? 128 >> l : 2 << l;
            g   = j / len;
            a   = g * 2 * len + j % len;
            b   = a + len;
            tw  = md == 0 ? (1 << l) + g : (128 >> l) - 1 - g;
        end
    endfunction

    task automatic check_cycle(input int md, input int c);
        int nl, dc, l, j, a, b, tw, le;
        nl = md == 2 ? 1 : 7;
        dc = 1 + nl * P;
        cur_c = c;
        chk("busy", busy, int'(c >= 1 && c < dc));
        chk("done", done, int'(c == dc));
        le = (c < 1 || c > dc) ? 0 : (c == dc ? nl - 1 : (c - 1) / P);
        chk("layer", layer, le);
        if (is_issue(md, c, l, j)) begin
            chk("rd_en", rd_en, 1);
            addr_of(md, l, j, a, b, tw);
            chk("rd_addr_a", rd_addr_a, a);
            chk("rd_addr_b", rd_addr_b, b);
            chk("tw_idx", tw_idx, tw);
        end else chk("rd_en", rd_en, 0);
        if (is_issue(md, c - D, l, j)) begin
            chk("wr_en", wr_en, 1);
            addr_of(md, l, j, a, b, tw);
            chk("wr_addr_a", wr_addr_a, a);
            chk("wr_addr_b", wr_addr_b, b);
        end else chk("wr_en", wr_en, 0);
        if (is_issue(md, c - MEM_LAT, l, j))
            chk("opcode", opcode, md == 2 ? (j % 2 == 0 ? 2 : 3) : md);
    endtask

    task automatic run(input int md, input bit noise, input int abort_c);
        int nl, dc, end_c, gap, haz;
        nl = md == 2 ? 1 : 7;
        dc = 1 + nl * P;
        end_c = abort_c > 0 ? abort_c : dc + 2;
        gap = 0;
        haz = 0;
        pend.delete();
        start = 1;
        mode = 2'(md);
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            check_cycle(md, c);
            while (pend.size() > 0 && pend[0].wc < c) void'(pend.pop_front());
            if (rd_en) begin
                foreach (pend[i])
                    if (pend[i].addr == int'(rd_addr_a) || pend[i].addr == int'(rd_addr_b)) haz++;
                if (gap > 0) chk("drain_gap", gap, D);
                gap = 0;
                pend.push_back('{int'(rd_addr_a), c + D});
                pend.push_back('{int'(rd_addr_b), c + D});
            end else if (busy) gap++;
            if (md < 2 && !noise && abort_c == 0) begin
                cap_a[md][c]  = rd_addr_a;
                cap_b[md][c]  = rd_addr_b;
                cap_tw[md][c] = tw_idx;
                cap_wr[md][c] = wr_en;
                cap_wa[md][c] = wr_addr_a;
                cap_dn[md][c] = done;
            end
            @(posedge clk);
            #1;
            rst   = abort_c > 0 && c + 1 == abort_c;
            start = noise && c + 1 < dc ? 1'($urandom) : 1'b0;
            mode  = noise ? 2'($urandom) : 2'(md);
        end
        if (abort_c > 0) begin
            @(negedge clk);
            cur_c = abort_c + 1;
            chk("abort_busy", busy, 0);
            chk("abort_rd_en", rd_en, 0);
            repeat (12) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                cur_c++;
                chk("abort_wr_en", wr_en, 0);
            end
            @(posedge clk);
            #1;
        end else begin
            cur_c = dc;
            chk("hazard", haz, 0);
            accepted++;
        end
    endtask

    task automatic reserved(input int md);
        start = 1;
        mode = 2'(md);
        repeat (4) begin
            @(negedge clk);
            chk("reserved_busy", busy, 0);
            chk("reserved_rd_en", rd_en, 0);
            @(posedge clk);
            #1;
        end
        start = 0;
    endtask

    initial begin
        int fw, nd, r;
        vt[0] = '{0, 1, 0, 128, 1};
        vt[1] = '{0, 128, 127, 255, 1};
        vt[2] = '{0, 1 + P + 64, 128, 192, 3};
        vt[3] = '{0, 128 + 6 * P, 253, 255, 127};
        vt[4] = '{1, 3, 4, 6, 126};
        vt[5] = '{1, 1 + 6 * P, 0, 128, 1};
        rst = 1;
        start = 0;
        mode = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_rd_addr_a", rd_addr_a, 0);
        chk("rst_rd_addr_b", rd_addr_b, 0);
        chk("rst_wr_addr_a", wr_addr_a, 0);
        chk("rst_wr_addr_b", wr_addr_b, 0);
        chk("rst_tw_idx", tw_idx, 0);
        chk("rst_layer", layer, 0);
        @(posedge clk);
        #1;
        rst = 0;
        run(0, 0, 0);
        run(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cur_c = vt[i].cyc;
            chk("vec_rd_addr_a", cap_a[vt[i].md][vt[i].cyc], vt[i].a);
            chk("vec_rd_addr_b", cap_b[vt[i].md][vt[i].cyc], vt[i].b);
            chk("vec_tw_idx", cap_tw[vt[i].md][vt[i].cyc], vt[i].tw);
        end
        fw = -1;
        nd = 0;
        for (int c = 0; c <= 934; c++) begin
            if (fw < 0 && cap_wr[0][c]) fw = c;
            if (cap_dn[0][c]) nd++;
        end
        cur_c = 6;
        chk("first_wr_cycle", fw, 6);
        if (fw >= 0) chk("first_wr_addr_a", cap_wa[0][fw], 0);
        cur_c = 932;
        chk("done_pulses", nd, 1);
        chk("done_at_932", int'(cap_dn[0][932]), 1);
        reserved(3);
        if (!PWM) reserved(2);
        run(0, 0, 300);
        run(0, 0, 0);
`ifdef NTT_CTRL_PWM_EN
        run(2, 0, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 3);
            if (r < 2 || (PWM && r == 2)) run(r, 1, 0);
            else reserved(r);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("done_count", done_cnt, accepted);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
